// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: processor-side memory bus slice seen by the UART transmitter.
//   ADDR  - processor word address
//   WDATA - processor write data (processor DATA_OUT)
//   READ  - processor read strobe
//   WRITE - processor write strobe
//   RDATA - register read data, zero unless a read hits the register window
//   SEL   - combinational window-hit indication
// master: processor side; slave: the UART register block.
interface mmio_uart_tx_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  READ;
  logic                  WRITE;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  SEL;

  modport master (
    output ADDR, WDATA, READ, WRITE,
    input  RDATA, SEL
  );

  modport slave (
    input  ADDR, WDATA, READ, WRITE,
    output RDATA, SEL
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter. Decodes a three-word register
// window on the processor bus, buffers written bytes in a FIFO and serializes
// them on TXD as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   CLK - system clock, rising edge
//   RST - asynchronous active-low reset
//   bus - mmio_uart_tx_if.slave (ADDR, WDATA, READ, WRITE in; RDATA, SEL out)
//   TXD - serial output, idle high, driven from a flop
// Registers (word offset from BASE_ADDR):
//   0 TXDATA  write pushes WDATA[7:0]; reads 0
//   1 STATUS  bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky),
//             bit4 parity advertised, bits[14:8] FIFO count
//   2 CTRL    bit0 enable; writing 1 to bit1 clears overflow (bit1 reads 0)
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data).
module mmio_uart_tx #(
  parameter int unsigned           ADDR_WIDTH   = 26,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 26'h3FFFFF0,
  parameter int unsigned           CLKS_PER_BIT = 16,
  parameter int unsigned           FIFO_DEPTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  mmio_uart_tx_if.slave        bus,
  output logic                 TXD
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  // ---------------- address decode ----------------
  // One extra bit keeps BASE_ADDR+2 from wrapping near the top of the map.
  logic [AW1-1:0] addr_ext;
  logic [AW1-1:0] base_ext;
  logic [AW1-1:0] off_ext;
  logic           sel;
  logic           hit_txdata;
  logic           hit_status;
  logic           hit_ctrl;

  assign addr_ext   = {1'b0, bus.ADDR};
  assign base_ext   = {1'b0, BASE_ADDR};
  assign off_ext    = addr_ext - base_ext;
  assign sel        = (addr_ext >= base_ext) && (addr_ext <= base_ext + AW1'(2));
  assign hit_txdata = sel && (off_ext == AW1'(0));
  assign hit_status = sel && (off_ext == AW1'(1));
  assign hit_ctrl   = sel && (off_ext == AW1'(2));

  logic wr_txdata;
  logic wr_ctrl;
  assign wr_txdata = bus.WRITE && hit_txdata;
  assign wr_ctrl   = bus.WRITE && hit_ctrl;

  // ---------------- state ----------------
  state_e           state_q,   state_d;
  logic [15:0]      baud_q,    baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             txd_q,     txd_d;
  logic             enable_q,  enable_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic             parity_q,  parity_d;
`endif

  logic fifo_full;
  logic fifo_empty;
  logic busy;
  logic baud_end;
  logic pop;
  logic push;
  logic overflow_set;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != ST_IDLE);
  assign baud_end   = (baud_q == BAUD_LAST);

  // ---------------- transmit FSM ----------------
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          // Chain straight into the next start bit so frames abut.
          if (enable_q && !fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    if ((state_d != state_q) || (state_q == ST_IDLE) || baud_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 16'd1;
    end

    // TXD is the registered line level for the state being entered.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // ---------------- FIFO and control registers ----------------
  // A push while full is still accepted when the FSM pops in the same cycle.
  assign push         = wr_txdata && (!fifo_full || pop);
  assign overflow_set = wr_txdata && fifo_full && !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    enable_d   = wr_ctrl ? bus.WDATA[0] : enable_q;
    overflow_d = overflow_q;
    if (overflow_set)               overflow_d = 1'b1;
    if (wr_ctrl && bus.WDATA[1])    overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.WDATA[7:0];
  end

  assign TXD = txd_q;

  // ---------------- read path ----------------
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    status       = '0;
    status[0]    = fifo_full;
    status[1]    = fifo_empty;
    status[2]    = busy;
    status[3]    = overflow_q;
`ifdef UART_TX_PARITY_EN
    status[4]    = 1'b1;
`endif
    status[14:8] = 7'(count_q);

    rdata = '0;
    if (bus.READ && sel) begin
      if (hit_status)    rdata    = status;
      else if (hit_ctrl) rdata[0] = enable_q;
    end
  end

  assign bus.RDATA = rdata;
  assign bus.SEL   = sel;

  logic unused_wdata;
  assign unused_wdata = ^bus.WDATA[DATA_WIDTH-1:8];

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 32;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [AW-1:0] BASE = 26'h3FFFFF0;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
  localparam logic [31:0] PAR_ADV    = 32'h10;
`else
  localparam int unsigned FRAME_BITS = 10;
  localparam logic [31:0] PAR_ADV    = 32'h0;
`endif
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  localparam logic [AW-1:0] A_TX   = BASE;
  localparam logic [AW-1:0] A_STAT = BASE + 26'd1;
  localparam logic [AW-1:0] A_CTRL = BASE + 26'd2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic TXD;

  int n_cmp = 0;
  int n_err = 0;

  mmio_uart_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mmio_uart_tx #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  // TXD line recorder, one sample per cycle on the falling edge.
  bit   log_en = 1'b0;
  logic txd_log[$];
  logic exp_log[$];
  always @(negedge CLK) if (log_en) txd_log.push_back(TXD);

  // ---------------- reference model ----------------
  function automatic logic frame_level(input logic [7:0] b, input int unsigned k);
    int unsigned slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (FRAME_BITS == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic exp_frame(input logic [7:0] b);
    for (int unsigned k = 0; k < FRAME_CYC; k++) exp_log.push_back(frame_level(b, k));
  endtask

  task automatic exp_idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) exp_log.push_back(1'b1);
  endtask

  function automatic logic [31:0] stat(input int unsigned cnt, input bit bsy, input bit ovf);
    logic [31:0] s;
    s       = PAR_ADV;
    s[0]    = (cnt == DEPTH);
    s[1]    = (cnt == 0);
    s[2]    = bsy;
    s[3]    = ovf;
    s[14:8] = 7'(cnt);
    return s;
  endfunction

  function automatic int stream_diff();
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i >= txd_log.size()) return i;
      if (txd_log[i] !== exp_log[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic log_start();
    txd_log.delete();
    exp_log.delete();
    log_en = 1'b1;
  endtask

  task automatic log_wait();
    for (int i = 0; i < 20000 && txd_log.size() < exp_log.size(); i++) @(posedge CLK);
    log_en = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.ADDR  = a;
    bus.WDATA = d;
    bus.WRITE = 1'b1;
    @(posedge CLK);
    #1;
    bus.WRITE = 1'b0;
    bus.WDATA = '0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d, output logic s);
    @(negedge CLK);
    bus.ADDR = a;
    bus.READ = 1'b1;
    #1;
    d = bus.RDATA;
    s = bus.SEL;
    #1;
    bus.READ = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic        s;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if (TXD !== 1'b1) begin
      n_err++; $display("FAIL reset_txd: got %b required 1", TXD);
    end
    @(negedge CLK);
    RST = 1'b1;
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(0, 0, 0)) begin
      n_err++; $display("FAIL reset_status: got %h required %h", rd, stat(0, 0, 0));
    end
    n_cmp++;
    if (s !== 1'b1) begin
      n_err++; $display("FAIL reset_sel_in: got %b required 1", s);
    end
    n_cmp++;
    if (TXD !== 1'b1) begin
      n_err++; $display("FAIL reset_txd_after: got %b required 1", TXD);
    end
    bus_read(BASE - 26'd1, rd, s);
    n_cmp++;
    if (s !== 1'b0 || rd !== 32'h0) begin
      n_err++; $display("FAIL sel_below: got sel=%b rdata=%h required sel=0 rdata=0", s, rd);
    end
    bus_read(BASE + 26'd3, rd, s);
    n_cmp++;
    if (s !== 1'b0 || rd !== 32'h0) begin
      n_err++; $display("FAIL sel_above: got sel=%b rdata=%h required sel=0 rdata=0", s, rd);
    end
    bus_read(A_CTRL, rd, s);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL reset_ctrl: got %h required 0", rd);
    end
    // A write just outside the window must not reach the FIFO.
    bus_write(BASE - 26'd1, 32'h5A);
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(0, 0, 0)) begin
      n_err++; $display("FAIL stray_write: got %h required %h", rd, stat(0, 0, 0));
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic        s;
    logic [7:0]  bytes[5];
    int          d;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h07;
    for (int i = 2; i < 5; i++) bytes[i] = 8'($urandom);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, rd, s);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_err++; $display("FAIL ctrl_enable: got %h required 1", rd);
    end
    for (int i = 0; i < 5; i++) begin
      bus_write(A_TX, {24'h0, bytes[i]});
      log_start();
      exp_idle(1);
      exp_frame(bytes[i]);
      exp_idle(4);
      repeat (20) @(posedge CLK);
      bus_read(A_STAT, rd, s);
      n_cmp++;
      if (rd !== stat(0, 1, 0)) begin
        n_err++; $display("FAIL busy_mid_frame[%0d]: got %h required %h", i, rd, stat(0, 1, 0));
      end
      log_wait();
      d = stream_diff();
      n_cmp++;
      if (d != -1) begin
        n_err++;
        $display("FAIL frame_%02h: TXD at sample %0d got %b required %b", bytes[i], d,
                 (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
      end
      bus_read(A_STAT, rd, s);
      n_cmp++;
      if (rd !== stat(0, 0, 0)) begin
        n_err++; $display("FAIL idle_after_frame[%0d]: got %h required %h", i, rd, stat(0, 0, 0));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic        s;
    logic [7:0]  bytes[9];
    int          d;
    for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) bus_write(A_TX, {24'h0, bytes[i]});
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(8, 0, 0)) begin
      n_err++; $display("FAIL fifo_full: got %h required %h", rd, stat(8, 0, 0));
    end
    bus_write(A_TX, {24'h0, bytes[8]});
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(8, 0, 1)) begin
      n_err++; $display("FAIL overflow_set: got %h required %h", rd, stat(8, 0, 1));
    end
    bus_read(A_TX, rd, s);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL txdata_read: got %h required 0", rd);
    end
    bus_write(A_CTRL, 32'h3);
    log_start();
    exp_idle(1);
    for (int i = 0; i < 8; i++) exp_frame(bytes[i]);
    exp_idle(4);
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(8, 0, 0)) begin
      n_err++; $display("FAIL overflow_clear: got %h required %h", rd, stat(8, 0, 0));
    end
    log_wait();
    d = stream_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL overflow_drain: TXD at sample %0d got %b required %b", d,
               (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
    end
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(0, 0, 0)) begin
      n_err++; $display("FAIL overflow_drained: got %h required %h", rd, stat(0, 0, 0));
    end
    bus_read(A_CTRL, rd, s);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_err++; $display("FAIL ctrl_bit1_reads0: got %h required 1", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        s;
    logic [7:0]  bytes[3];
    int          d;
    for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
    bus_write(A_TX, {24'h0, bytes[0]});
    log_start();
    exp_idle(1);
    for (int i = 0; i < 3; i++) exp_frame(bytes[i]);
    exp_idle(4);
    bus_write(A_TX, {24'h0, bytes[1]});
    bus_write(A_TX, {24'h0, bytes[2]});
    log_wait();
    d = stream_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL back_to_back: TXD at sample %0d got %b required %b", d,
               (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
    end
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(0, 0, 0)) begin
      n_err++; $display("FAIL b2b_idle: got %h required %h", rd, stat(0, 0, 0));
    end
  endtask

  task automatic test_full_pop_wrap();
    logic [31:0] rd;
    logic        s;
    logic [7:0]  bytes[16];
    int          d;
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
    // Nine pushes on consecutive edges: one is popped at once, eight stay queued.
    bus_write(A_TX, {24'h0, bytes[0]});
    log_start();
    exp_idle(1);
    for (int i = 0; i < 10; i++) exp_frame(bytes[i]);
    exp_idle(4);
    for (int i = 1; i < 9; i++) bus_write(A_TX, {24'h0, bytes[i]});
    repeat (31) @(posedge CLK);
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(8, 1, 0)) begin
      n_err++; $display("FAIL full_before_pop: got %h required %h", rd, stat(8, 1, 0));
    end
    // This push lands on the edge that ends the first frame and pops the next byte.
    bus_write(A_TX, {24'h0, bytes[9]});
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(8, 1, 0)) begin
      n_err++; $display("FAIL push_on_pop: got %h required %h", rd, stat(8, 1, 0));
    end
    log_wait();
    d = stream_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL full_pop_stream: TXD at sample %0d got %b required %b", d,
               (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
    end
    bus_write(A_CTRL, 32'h0);
    for (int i = 10; i < 16; i++) bus_write(A_TX, {24'h0, bytes[i]});
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(6, 0, 0)) begin
      n_err++; $display("FAIL wrap_count: got %h required %h", rd, stat(6, 0, 0));
    end
    bus_write(A_CTRL, 32'h1);
    log_start();
    exp_idle(1);
    for (int i = 10; i < 16; i++) exp_frame(bytes[i]);
    exp_idle(4);
    log_wait();
    d = stream_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL wrap_order: TXD at sample %0d got %b required %b", d,
               (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic        s;
    logic [7:0]  b0;
    int          d;
    // Data bit 2 occupies frame cycles 12..15; force it low so the reset edge is visible.
    b0 = 8'($urandom) & 8'hFB;
    bus_write(A_TX, {24'h0, b0});
    bus_write(A_TX, {24'h0, 8'($urandom)});
    bus_write(A_TX, {24'h0, 8'($urandom)});
    repeat (14) @(posedge CLK);
    #1;
    n_cmp++;
    if (TXD !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_bit: got %b required 0", TXD);
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if (TXD !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_frame_txd: got %b required 1", TXD);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    bus_read(A_STAT, rd, s);
    n_cmp++;
    if (rd !== stat(0, 0, 0)) begin
      n_err++; $display("FAIL status_after_reset: got %h required %h", rd, stat(0, 0, 0));
    end
    bus_read(A_CTRL, rd, s);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL ctrl_after_reset: got %h required 0", rd);
    end
    bus_write(A_CTRL, 32'h1);
    log_start();
    exp_idle(20);
    log_wait();
    d = stream_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL fifo_discarded: TXD at sample %0d got %b required %b", d,
               (d < txd_log.size()) ? txd_log[d] : 1'bz, exp_log[d]);
    end
  endtask

  initial begin
    bus.ADDR  = '0;
    bus.WDATA = '0;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_full_pop_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
